// File: rtl/pcileech_com_tx_arb.sv
// pcileech_com_tx_arb: round-robin burst arbiter for the host-bound TX path.
// Three 32-bit word-stream requesters share one registered write port into
// the TX clock-crossing FIFO. Whole bursts are granted. A grant ends on the
// requester's last word, after MAX_BURST words, or after IDLE_TIMEOUT
// cycles without a valid word.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   req_data[95:0]  requester i word at [32*i+31:32*i]
//   req_valid[2:0]  word valid per requester
//   req_last[2:0]   final word of burst (qualified by valid)
//   req_ready[2:0]  word accepted when valid & ready
//   com_din         registered word toward the TX FIFO
//   com_din_wr_en   registered write strobe toward the TX FIFO
//   com_din_ready   TX FIFO not almost-full
//   grant_id        current owner, 2'b11 = none
//   busy            high outside IDLE
//   stat_split      one-cycle pulse after a forced burst end
//
// Optional build macro: PCILEECH_COM_TXARB_HDR_EN prefixes every grant with
// the header word {8'h77, 6'b0, grant_id, seq[15:0]}.

module pcileech_com_tx_arb #(
    parameter int MAX_BURST    = 256,
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [95:0] req_data,
    input  logic [2:0]  req_valid,
    input  logic [2:0]  req_last,
    output logic [2:0]  req_ready,
    output logic [31:0] com_din,
    output logic        com_din_wr_en,
    input  logic        com_din_ready,
    output logic [1:0]  grant_id,
    output logic        busy,
    output logic        stat_split
);

    localparam logic [1:0] S_IDLE = 2'd0;
`ifdef PCILEECH_COM_TXARB_HDR_EN
    localparam logic [1:0] S_HDR  = 2'd1;
`endif
    localparam logic [1:0] S_DATA = 2'd2;

    localparam logic [1:0] NONE = 2'b11;

    logic [1:0]  state;
    logic [1:0]  rr;
    logic [12:0] wcnt;
    logic [16:0] tcnt;

`ifdef PCILEECH_COM_TXARB_HDR_EN
    logic [15:0] seq;
`endif

    function automatic logic [1:0] inc3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // Round-robin pick: first valid requester starting at rr.
    logic [1:0] c0, c1, c2;
    logic [1:0] pick;
    logic       any_valid;

    always_comb begin
        c0 = rr;
        c1 = inc3(c0);
        c2 = inc3(c1);
        any_valid = |req_valid;
        if (req_valid[c0])
            pick = c0;
        else if (req_valid[c1])
            pick = c1;
        else
            pick = c2;
    end

    // Granted requester's signals, muxed by the registered owner.
    logic        gvalid;
    logic        glast;
    logic [31:0] gdata;

    always_comb begin
        gvalid = 1'b0;
        glast  = 1'b0;
        gdata  = '0;
        unique case (grant_id)
            2'd0: begin
                gvalid = req_valid[0];
                glast  = req_last[0];
                gdata  = req_data[31:0];
            end
            2'd1: begin
                gvalid = req_valid[1];
                glast  = req_last[1];
                gdata  = req_data[63:32];
            end
            2'd2: begin
                gvalid = req_valid[2];
                glast  = req_last[2];
                gdata  = req_data[95:64];
            end
            default: begin
                gvalid = 1'b0;
                glast  = 1'b0;
                gdata  = '0;
            end
        endcase
    end

    logic in_data;
    assign in_data = (state == S_DATA);

    // Ready follows the FIFO combinationally so a falling com_din_ready
    // blocks acceptance in the same cycle.
    always_comb begin
        req_ready = 3'b000;
        if (in_data) begin
            unique case (grant_id)
                2'd0:    req_ready = {2'b00, com_din_ready};
                2'd1:    req_ready = {1'b0, com_din_ready, 1'b0};
                2'd2:    req_ready = {com_din_ready, 2'b00};
                default: req_ready = 3'b000;
            endcase
        end
    end

    logic        accept;
    logic [12:0] wnext;
    logic [16:0] tnext;
    logic        hit_max;
    logic        hit_to;
    logic        done;
    logic        forced;

    assign accept  = in_data & gvalid & com_din_ready;
    assign wnext   = wcnt + 13'd1;
    assign tnext   = tcnt + 17'd1;
    assign hit_max = (wnext == 13'(MAX_BURST));

    // Stalled-by-FIFO cycles do not advance the idle timeout.
    assign hit_to = in_data & ~gvalid & com_din_ready
                  & (tnext == 17'(IDLE_TIMEOUT));

    // A last word that also fills the burst is a normal end.
    assign done   = (accept & (glast | hit_max)) | hit_to;
    assign forced = (accept & hit_max & ~glast) | hit_to;

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            grant_id      <= NONE;
            rr            <= 2'd0;
            wcnt          <= '0;
            tcnt          <= '0;
            com_din       <= '0;
            com_din_wr_en <= 1'b0;
            stat_split    <= 1'b0;
`ifdef PCILEECH_COM_TXARB_HDR_EN
            seq           <= '0;
`endif
        end else begin
            com_din_wr_en <= 1'b0;
            stat_split    <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (any_valid) begin
                        grant_id <= pick;
                        wcnt     <= '0;
                        tcnt     <= '0;
`ifdef PCILEECH_COM_TXARB_HDR_EN
                        state    <= S_HDR;
`else
                        state    <= S_DATA;
`endif
                    end
                end
`ifdef PCILEECH_COM_TXARB_HDR_EN
                S_HDR: begin
                    if (com_din_ready) begin
                        com_din       <= {8'h77, 6'b0, grant_id, seq};
                        com_din_wr_en <= 1'b1;
                        seq           <= seq + 16'd1;
                        state         <= S_DATA;
                    end
                end
`endif
                S_DATA: begin
                    if (accept) begin
                        com_din       <= gdata;
                        com_din_wr_en <= 1'b1;
                        wcnt          <= wnext;
                    end
                    if (gvalid)
                        tcnt <= '0;
                    else if (com_din_ready)
                        tcnt <= tnext;
                    if (done) begin
                        state      <= S_IDLE;
                        grant_id   <= NONE;
                        rr         <= inc3(grant_id);
                        stat_split <= forced;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    grant_id <= NONE;
                end
            endcase
        end
    end

endmodule
